// File: rtl/speedy_arbiter.sv
// speedy_arbiter: two-requester front end for a single shared Speedy core.
// Requests are granted one at a time. The granted plaintext and key are
// registered onto the core inputs. The core output is captured a fixed
// CORE_LAT cycles later and held until the result consumer accepts it.
// When both requesters are valid, a round-robin pointer gives priority
// to the requester that was not served last.
module speedy_arbiter #(
  parameter int W        = 192,
  parameter int CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic [W-1:0] req0_key,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  input  logic [W-1:0] req1_key,

  output logic [W-1:0] core_f_in,
  output logic [W-1:0] core_K,
  input  logic [W-1:0] core_f_out,

  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_id,

  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // The counter is 4 bits wide because CORE_LAT never exceeds 15.
  localparam logic [3:0] LAT_LOAD = 4'(CORE_LAT);

  state_t       state_reg;
  state_t       state_next;
  logic         rr_reg;
  logic [3:0]   cnt_reg;

  logic         grant;
  logic         accept;
  logic         run_done;
  logic         hold_exit;
  logic [W-1:0] grant_data;
  logic [W-1:0] grant_key;

  // Grant selection: a lone valid requester wins; a tie goes to rr_reg.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = rr_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readys are only offered in IDLE, and never while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst && (state_reg == IDLE)) begin
      req0_ready = req0_valid && !grant;
      req1_ready = req1_valid &&  grant;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    grant_data = req0_data;
    grant_key  = req0_key;
    if (grant) begin
      grant_data = req1_data;
      grant_key  = req1_key;
    end
  end

  // A ready is asserted only when its valid is high, so either ready is a transfer.
  assign accept    = req0_ready || req1_ready;
  // A count of 1 marks the edge on which the core output becomes valid.
  // A count of 0 can only appear if CORE_LAT is misconfigured, so it is
  // also treated as done rather than left to wrap around.
  assign run_done  = (state_reg == RUN) && (cnt_reg <= 4'd1);
  assign hold_exit = (state_reg == HOLD) && res_ready;

  assign res_valid = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);

  // Next-state logic for IDLE -> RUN -> HOLD -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (run_done) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg <= LAT_LOAD;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  // The core operands and the owner id load on acceptance. They hold until the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_f_in <= '0;
      core_K    <= '0;
      res_id    <= 1'b0;
    end else if (accept) begin
      core_f_in <= grant_data;
      core_K    <= grant_key;
      res_id    <= grant;
    end
  end

  // Capture the core output on the last RUN edge. The value stays stable through HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_data <= '0;
    end else if (run_done) begin
      res_data <= core_f_out;
    end
  end

  // When a result is consumed, the requester just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_reg <= 1'b0;
    end else if (hold_exit) begin
      rr_reg <= ~res_id;
    end
  end

  // Structural invariants of the handshake.
  a_ready_exclusive : assert property (@(posedge clk) !(req0_ready && req1_ready));

  a_no_ready_busy : assert property (@(posedge clk)
    (state_reg != IDLE) |-> !(req0_ready || req1_ready));

  a_core_operands_hold : assert property (@(posedge clk) disable iff (!rst)
    !accept |=> ($stable(core_f_in) && $stable(core_K)));

  a_result_hold : assert property (@(posedge clk) disable iff (!rst)
    ((state_reg == HOLD) && !res_ready) |=>
      ((state_reg == HOLD) && $stable(res_data) && $stable(res_id)));

endmodule

// File: tb/tb_speedy_arbiter.sv
// Testbench for speedy_arbiter. Two instances share one stimulus stream:
// lane 0 uses CORE_LAT=2 and lane 1 uses CORE_LAT=1. Each lane has a
// pipelined XOR core model and a timestamp-based reference model. It also
// has a scoreboard queue that a separate monitor reads whenever res_valid is high.
module tb_speedy_arbiter;
  localparam int W  = 192;
  localparam int NL = 2;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, res_ready;
  logic [W-1:0] req0_data, req0_key, req1_data, req1_key;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int ln, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d actual=%0h required=%0h", name, ln, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : lane
      localparam int LAT = (gi == 0) ? 2 : 1;

      logic         req0_ready, req1_ready, res_valid, res_id, busy;
      logic [W-1:0] core_f_in, core_K, core_f_out, res_data;
      logic [W-1:0] pipe [0:14];

      speedy_arbiter #(.W(W), .CORE_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_key   (req0_key),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_key   (req1_key),
        .core_f_in  (core_f_in),
        .core_K     (core_K),
        .core_f_out (core_f_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
      );

      // Core model: the output is f_in ^ K, valid LAT-1 cycles after the inputs change.
      always @(posedge clk) begin
        pipe[0] <= core_f_in ^ core_K;
        for (int i = 1; i < 15; i++) pipe[i] <= pipe[i-1];
      end
      if (LAT == 1) begin : comb_core
        assign core_f_out = core_f_in ^ core_K;
      end else begin : pipe_core
        assign core_f_out = pipe[LAT-2];
      end

      // Reference model state (owned by the model process).
      exp_t         sb [$];
      int           vfrom = 0;
      bit           armed = 1'b0;
      int           t = 0;
      bit           m_busy = 1'b0, m_rr = 1'b0, m_id = 1'b0;
      int           m_hold = 0;
      logic [W-1:0] m_f = '0, m_k = '0, m_res = '0;
      int           acc_id [$];
      int           acc_cyc [$];

      // Reference model: an acceptance in cycle c shows a result from cycle c+LAT+1 until consumed.
      always @(negedge clk) begin : model
        bit v0, v1, g, hv, er0, er1;
        #1;
        hv = m_busy && (t >= m_hold);
        if (m_busy && (t == m_hold)) m_res = m_f ^ m_k;
        v0  = (req0_valid === 1'b1);
        v1  = (req1_valid === 1'b1);
        g   = (v0 && v1) ? m_rr : v1;
        er0 = (rst === 1'b1) && !m_busy && v0 && !g;
        er1 = (rst === 1'b1) && !m_busy && v1 && g;
        if (armed) begin
          chk("ready0", gi, W'(req0_ready), W'(er0));
          chk("ready1", gi, W'(req1_ready), W'(er1));
          chk("busy", gi, W'(busy), W'(m_busy));
          chk("res_valid", gi, W'(res_valid), W'(hv));
          chk("core_f_in", gi, core_f_in, m_f);
          chk("core_K", gi, core_K, m_k);
          chk("res_id", gi, W'(res_id), W'(m_id));
          chk("res_data_held", gi, res_data, m_res);
          if (rst === 1'b1 && v0 && req0_ready === 1'b1) begin
            acc_id.push_back(0);
            acc_cyc.push_back(t);
          end
          if (rst === 1'b1 && v1 && req1_ready === 1'b1) begin
            acc_id.push_back(1);
            acc_cyc.push_back(t);
          end
        end
        if (rst !== 1'b1) begin
          armed  = 1'b1;
          m_busy = 1'b0;
          m_rr   = 1'b0;
          m_id   = 1'b0;
          m_f    = '0;
          m_k    = '0;
          m_res  = '0;
          vfrom  = sb.size();
        end else if (!m_busy && (v0 || v1)) begin
          m_busy = 1'b1;
          m_hold = t + LAT + 1;
          m_id   = g;
          m_f    = g ? req1_data : req0_data;
          m_k    = g ? req1_key : req0_key;
          sb.push_back('{id: g, res: m_f ^ m_k});
        end else if (hv && res_ready === 1'b1) begin
          m_busy = 1'b0;
          m_rr   = !m_id;
        end
        t++;
      end

      // Monitor: whenever a result is presented, compare it with the oldest live entry.
      int rd = 0;
      always @(negedge clk) begin : monitor
        if (rd < vfrom) rd = vfrom;
        if (armed && res_valid === 1'b1) begin
          if (rd >= sb.size()) begin
            checks++;
            errors++;
            $display("FAIL sb_result lane%0d actual=res_valid required=no_result", gi);
          end else begin
            chk("sb_res_data", gi, res_data, sb[rd].res);
            chk("sb_res_id", gi, W'(res_id), W'(sb[rd].id));
            if (res_ready === 1'b1 && rst === 1'b1) rd++;
          end
        end
      end
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_order(input int ln, input int lat, input int ids[$],
                             input int cyc[$], input int base);
    if (ids.size() < base + 3) begin
      checks++;
      errors++;
      $display("FAIL grant_count lane%0d actual=%0d required=3", ln, ids.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("grant_order", ln, W'(ids[base+k]), W'(k % 2));
        if (k > 0) chk("grant_spacing", ln, W'(cyc[base+k] - cyc[base+k-1]), W'(lat + 2));
      end
    end
  endtask

  initial begin
    int b0, b1;
    logic [W-1:0] d, k;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    $display("reset state checked; starting single operation");

    // Single operation 0x1 / 0x2, with a withdrawn req1 pulse while busy.
    req0_valid = 1'b1; req0_data = W'(1); req0_key = W'(2); res_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = rnd(); req1_key = rnd();
    step();
    req1_valid = 1'b0;
    step();
    chk("single_res_valid", 0, W'(lane[0].res_valid), W'(1));
    chk("single_res_data", 0, lane[0].res_data, W'(3));
    chk("single_res_id", 0, W'(lane[0].res_id), W'(0));
    chk("single_res_data", 1, lane[1].res_data, W'(3));
    repeat (3) step();
    $display("single operation done; starting backpressure");

    // Backpressure: result held in HOLD while res_ready stays low.
    d = rnd(); k = rnd();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = d; req0_key = k;
    step();
    req0_valid = 1'b0;
    repeat (3) step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = rnd(); req1_data = rnd();
    repeat (10) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("bp_res_valid", 0, W'(lane[0].res_valid), W'(1));
    chk("bp_res_data", 0, lane[0].res_data, d ^ k);
    chk("bp_res_data", 1, lane[1].res_data, d ^ k);
    res_ready = 1'b1;
    step();
    step();
    chk("bp_exit", 0, W'(lane[0].res_valid), W'(0));
    chk("bp_exit", 1, W'(lane[1].res_valid), W'(0));
    repeat (2) step();
    $display("backpressure done; starting mid-operation reset");

    // Mid-operation reset: requester 0 is preferred afterwards even though rr was 1.
    b0 = lane[0].acc_id.size(); b1 = lane[1].acc_id.size();
    req0_valid = 1'b1; req0_data = rnd(); req0_key = rnd();
    step();
    req0_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_busy", 0, W'(lane[0].busy), W'(0));
    chk("rst_res_data", 0, lane[0].res_data, W'(0));
    chk("rst_core_f_in", 0, lane[0].core_f_in, W'(0));
    chk("rst_core_K", 1, lane[1].core_K, W'(0));
    req0_valid = 1'b1; req1_valid = 1'b1; req1_data = rnd(); req1_key = rnd();
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (lane[0].acc_id.size() > b0 + 1) chk("post_rst_grant", 0, W'(lane[0].acc_id[b0+1]), W'(0));
    else begin checks++; errors++; $display("FAIL post_rst_grant lane0 actual=none required=0"); end
    if (lane[1].acc_id.size() > b1 + 1) chk("post_rst_grant", 1, W'(lane[1].acc_id[b1+1]), W'(0));
    else begin checks++; errors++; $display("FAIL post_rst_grant lane1 actual=none required=0"); end
    repeat (6) step();
    $display("mid-operation reset done; starting simultaneous requests");

    // Simultaneous continuous requests right after reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    b0 = lane[0].acc_id.size(); b1 = lane[1].acc_id.size();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_data = rnd(); req0_key = rnd(); req1_data = rnd(); req1_key = rnd();
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) step();
    check_order(0, 2, lane[0].acc_id, lane[0].acc_cyc, b0);
    check_order(1, 1, lane[1].acc_id, lane[1].acc_cyc, b1);
    $display("simultaneous requests done; starting random traffic");

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_data = rnd(); req0_key = rnd(); req1_data = rnd(); req1_key = rnd();
      res_ready = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 199) != 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1; rst = 1'b1;
    repeat (10) step();
    $display("random traffic done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speedy_arbiter.md
SPEEDY_ARBITER -- requirements
Module: speedy_arbiter

Interface
REQ-001 Parameters SHALL be:
- W, default 192, block and key width in bits.
- CORE_LAT, default 2, core clock cycles from driving the core inputs to a valid core output; legal range 1..15.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_data  in  W  requester 0 plaintext.
- req0_key  in  W  requester 0 key.
- req1_valid, req1_ready, req1_data, req1_key  SHALL be identical to the requester 0 set, for requester 1.
- core_f_in  out  W  registered plaintext driven to the shared Speedy core.
- core_K  out  W  registered key driven to the shared Speedy core.
- core_f_out  in  W  ciphertext returned by the shared core.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts the result.
- res_data  out  W  captured ciphertext.
- res_id  out  1  index of the requester that owns res_data.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.

REQ-004 IDLE arbitration:
- The granted requester SHALL be the one with valid high.
- If both valids are high, the grant SHALL go to the requester indicated by the round-robin pointer rr.
- reqN_ready SHALL be high only in IDLE, only for the granted requester, and combinationally.

REQ-005 Acceptance:
- A transfer occurs when valid and ready are both high.
- On that edge, core_f_in and core_K SHALL load the granted data and key.
- res_id SHALL load the grant index.
- A down-counter SHALL load CORE_LAT.
- The FSM SHALL move to RUN.

REQ-006 In RUN:
- The counter SHALL decrement by 1 each cycle.
- On the edge where the counter equals 1, res_data SHALL capture core_f_out and the FSM SHALL move to HOLD.
- core_f_out is therefore sampled exactly CORE_LAT cycles after the acceptance edge.

REQ-007 core_f_in and core_K SHALL hold their values unchanged from acceptance until the next acceptance.

REQ-008 In HOLD:
- res_valid SHALL be 1.
- res_data and res_id SHALL be stable.
- The FSM SHALL return to IDLE on the first edge with res_ready high.
- res_valid SHALL fall in the following cycle.

REQ-009 rr SHALL update only on the HOLD-to-IDLE edge, to the index not equal to res_id, so the last-served requester gets lowest priority.

REQ-010 No requester SHALL be accepted in RUN or HOLD: both readys SHALL be 0 there.

REQ-011 An operation accepted in IDLE SHALL NOT be accepted in the same cycle that HOLD exits.
- Minimum spacing between acceptances SHALL be CORE_LAT+2 cycles.

REQ-012 A requester that drops valid before acceptance SHALL lose its request with no side effect.

REQ-013 res_ready asserted outside HOLD SHALL be ignored.

REQ-014 With continuous requests from both requesters, grants SHALL alternate 0,1,0,1,...

Reset
REQ-015 With rst low at a rising edge, the next state SHALL be:
- state IDLE;
- rr = 0;
- counter = 0;
- core_f_in, core_K, res_data, res_id, res_valid, busy all 0.

REQ-016 Reset asserted in RUN or HOLD SHALL abandon the operation and produce no result.
- The first cycle after rst returns high SHALL be IDLE with requester 0 preferred.

REQ-017 Both readys SHALL be 0 while rst is low.

Verification
REQ-018 Single operation, CORE_LAT=2:
- Stimulus: req0 valid, data=0x1, key=0x2 at cycle 0; core model returns f_in XOR K.
- Response: ready0=1 in cycle 0; core_f_in=0x1 from cycle 1; res_valid=1 in cycle 3 with res_data=0x3 and res_id=0.

REQ-019 Simultaneous requests after reset:
- Stimulus: both valids high with res_ready=1.
- Response: grant order 0,1,0; acceptances 4 cycles apart.

REQ-020 Backpressure:
- Stimulus: res_ready held 0 for 10 cycles in HOLD.
- Response: res_valid, res_data and res_id stable throughout; both readys 0; exit one cycle after res_ready rises.

REQ-021 Mid-operation reset:
- Stimulus: rst low for 1 cycle in RUN.
- Response: all outputs 0 on the next cycle; no res_valid pulse; the next accepted request when both are valid is requester 0.

REQ-022 Withdrawn request:
- Stimulus: req1_valid pulses for one cycle while busy, then drops.
- Response: no acceptance and no rr change.

REQ-023 CORE_LAT=1:
- Stimulus: a single request on either requester.
- Response: core_f_out sampled on the edge following acceptance.
